// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Debug-side reader that walks every register of the CPU register file
// through its combinational read port. Each word is serialized least
// significant byte first onto a valid/ready byte stream that feeds the debug
// UART transmitter.
//
// Flow per dump: IDLE -> (LOAD -> SEND x NBYTES) x NREGS -> DONE -> IDLE.
// All outputs come straight from flops. Their next values are derived from
// the next-state values, so they line up exactly with the state they describe.

module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NREGS      = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    // Bytes per register word, and the width of the byte counter.
    // The counter is kept at least one bit wide for 8-bit registers.
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NREGS - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    // FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] raddr_q,    raddr_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic                  handshake_s;
    logic                  last_byte_s;
    logic                  last_reg_s;

    // A byte leaves only when it is actually offered and the transmitter
    // takes it. tx_valid_q is high exactly while in SEND.
    assign handshake_s = tx_valid_q && i_tx_ready;
    assign last_byte_s = (cnt_q == LAST_BYTE);
    assign last_reg_s  = (raddr_q == LAST_ADDR);

    // Next-state logic: sequencing of registers and bytes within a register.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    raddr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The read address has been stable since the previous edge, so
                // the regfile's combinational data is settled here.
                shift_d = i_rdata;
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (handshake_s) begin
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (last_byte_s) begin
                        if (last_reg_s) begin
                            state_d = ST_DONE;
                        end else begin
                            // Only address change in a dump: the LOAD entry edge.
                            raddr_d = raddr_q + ADDR_ONE;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    // Stall: everything visible to the transmitter holds.
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                raddr_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                raddr_d = '0;
                cnt_d   = '0;
                shift_d = '0;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    // without adding a cycle of latency.
    always_comb begin
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        if (state_d == ST_SEND) begin
            tx_data_d = shift_d[7:0];
        end else begin
            // The data bus is quiet whenever no byte is offered.
            tx_data_d = 8'h00;
        end
    end

    // State and output registers. Reset clears them at once, even mid-dump.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            raddr_q    <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_raddr    = raddr_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader at default parameters.
// A regfile model returns 0xA0000000+k for register k (register 0 reads 0).
// The reference byte stream is computed arithmetically from that rule.

module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready = 1'b1;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [7:0]  txd;
    logic        valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Monitor and scoreboard state.
    int   byte_idx = 0;
    int   done_cnt = 0;
    logic rand_ready = 1'b0;
    int   stall_left = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [4:0] prev_raddr = 5'd0;

    always #5 clk = ~clk;

    assign rdata = (raddr == 5'd0) ? 32'h0000_0000 : (32'hA000_0000 + {27'd0, raddr});

    regfile_dump_reader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NREGS(32)
    ) dut (
        .clk(clk),
        .i_rst(rst),
        .i_start(start),
        .o_raddr(raddr),
        .i_rdata(rdata),
        .o_tx_data(txd),
        .o_tx_valid(valid),
        .i_tx_ready(ready),
        .o_busy(busy),
        .o_done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected n-th byte of a dump: register n/4, byte n%4, LSB first.
    function automatic logic [7:0] exp_byte(input int idx);
        int i;
        int r;
        int b;
        logic [31:0] w;
        i = idx % 128;
        r = i / 4;
        b = i % 4;
        w = (r == 0) ? 32'h0 : (32'hA000_0000 + r);
        return 8'((w >> (8 * b)) & 32'h0000_00FF);
    endfunction

    // Monitor: stall stability, quiet data bus, byte scoreboard, ready driver.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            stall_left = 0;
            ready = 1'b1;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, valid}, 32'd1);
                chk("stall_data", {24'd0, txd}, {24'd0, prev_data});
                chk("stall_raddr", {27'd0, raddr}, {27'd0, prev_raddr});
            end
            if (!valid) chk("data_quiet", {24'd0, txd}, 32'd0);
            if (done) done_cnt++;
            if (!rand_ready) begin
                ready = 1'b1;
            end else if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 29) == 0) begin
                ready = 1'b0;
                stall_left = 19;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            // valid && ready here means a handshake at the coming rising edge.
            if (valid && ready) begin
                chk("byte", {24'd0, txd}, {24'd0, exp_byte(byte_idx)});
                byte_idx++;
            end
            prev_stall = valid && !ready;
            prev_data  = txd;
            prev_raddr = raddr;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for o_done; also report whether busy ever dropped.
    task automatic wait_done(input string name, input int budget, output int n, output logic busy_gap);
        n = 0;
        busy_gap = 1'b0;
        while (done !== 1'b1 && n < budget) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        int         off;
        logic       valid;
        logic       busy;
        logic       done;
        logic [4:0] raddr;
        logic [7:0] data;
    } vec_t;

    vec_t vec[13];

    int   n;
    logic gap;
    logic found;
    logic idle_bad;

    initial begin
        // Offsets are counted in falling edges after the edge that samples i_start.
        vec[0]  = '{0,   1'b0, 1'b1, 1'b0, 5'd0,  8'h00};
        vec[1]  = '{1,   1'b1, 1'b1, 1'b0, 5'd0,  8'h00};
        vec[2]  = '{4,   1'b1, 1'b1, 1'b0, 5'd0,  8'h00};
        vec[3]  = '{5,   1'b0, 1'b1, 1'b0, 5'd1,  8'h00};
        vec[4]  = '{6,   1'b1, 1'b1, 1'b0, 5'd1,  8'h01};
        vec[5]  = '{7,   1'b1, 1'b1, 1'b0, 5'd1,  8'h00};
        vec[6]  = '{9,   1'b1, 1'b1, 1'b0, 5'd1,  8'hA0};
        vec[7]  = '{10,  1'b0, 1'b1, 1'b0, 5'd2,  8'h00};
        vec[8]  = '{155, 1'b0, 1'b1, 1'b0, 5'd31, 8'h00};
        vec[9]  = '{156, 1'b1, 1'b1, 1'b0, 5'd31, 8'h1F};
        vec[10] = '{159, 1'b1, 1'b1, 1'b0, 5'd31, 8'hA0};
        vec[11] = '{160, 1'b0, 1'b1, 1'b1, 5'd31, 8'h00};
        vec[12] = '{161, 1'b0, 1'b0, 1'b0, 5'd0,  8'h00};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_raddr", {27'd0, raddr}, 32'd0);
        chk("rst_data", {24'd0, txd}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Dump with ready held high: cycle-exact table.
        rand_ready = 1'b0;
        byte_idx = 0;
        done_cnt = 0;
        pulse_start();
        for (int j = 0; j <= 163; j++) begin
            if (j > 0) @(negedge clk);
            chk("busy_window", {31'd0, busy}, {31'd0, (j <= 160)});
            for (int t = 0; t < 13; t++) begin
                if (vec[t].off == j) begin
                    chk("tbl_valid", {31'd0, valid}, {31'd0, vec[t].valid});
                    chk("tbl_busy", {31'd0, busy}, {31'd0, vec[t].busy});
                    chk("tbl_done", {31'd0, done}, {31'd0, vec[t].done});
                    chk("tbl_raddr", {27'd0, raddr}, {27'd0, vec[t].raddr});
                    chk("tbl_data", {24'd0, txd}, {24'd0, vec[t].data});
                end
            end
        end
        chk("a_bytes", byte_idx, 32'd128);
        chk("a_done_cnt", done_cnt, 32'd1);

        // Dump with random backpressure and 20-cycle stalls.
        rand_ready = 1'b1;
        byte_idx = 0;
        done_cnt = 0;
        pulse_start();
        wait_done("b_done_seen", 4000, n, gap);
        chk("b_busy_gap", {31'd0, gap}, 32'd0);
        repeat (3) @(negedge clk);
        chk("b_bytes", byte_idx, 32'd128);
        chk("b_done_cnt", done_cnt, 32'd1);
        chk("b_idle", {31'd0, busy}, 32'd0);

        // i_start re-pulsed during register 5 SEND and during DONE.
        byte_idx = 0;
        done_cnt = 0;
        pulse_start();
        n = 0;
        found = 1'b0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            found = (raddr == 5'd5) && valid;
        end
        chk("c_reg5_seen", {31'd0, found}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("c_done_seen", 4000, n, gap);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("c_idle_after_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("c_still_idle", {31'd0, busy}, 32'd0);
        chk("c_bytes", byte_idx, 32'd128);
        chk("c_done_cnt", done_cnt, 32'd1);

        // Asynchronous reset mid-byte on register 10.
        rand_ready = 1'b0;
        byte_idx = 0;
        pulse_start();
        n = 0;
        found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            found = (raddr == 5'd10) && valid;
        end
        chk("d_reg10_seen", {31'd0, found}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("d_async_valid", {31'd0, valid}, 32'd0);
        chk("d_async_busy", {31'd0, busy}, 32'd0);
        chk("d_async_raddr", {27'd0, raddr}, 32'd0);
        chk("d_async_data", {24'd0, txd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || valid || done) idle_bad = 1'b1;
        end
        chk("d_idle_after_rst", {31'd0, idle_bad}, 32'd0);
        byte_idx = 0;
        done_cnt = 0;
        pulse_start();
        chk("d_restart_raddr", {27'd0, raddr}, 32'd0);
        wait_done("d_done_seen", 400, n, gap);
        repeat (3) @(negedge clk);
        chk("d_bytes", byte_idx, 32'd128);
        chk("d_done_cnt", done_cnt, 32'd1);

        // i_start held high: back-to-back dumps with one IDLE cycle between.
        byte_idx = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        wait_done("e_done1_seen", 400, n, gap);
        @(negedge clk);
        chk("e_gap_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("e_gap_load_busy", {31'd0, busy}, 32'd1);
        chk("e_gap_load_raddr", {27'd0, raddr}, 32'd0);
        chk("e_gap_load_valid", {31'd0, valid}, 32'd0);
        wait_done("e_done2_seen", 400, n, gap);
        chk("e_period", n, 32'd160);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("e_bytes", byte_idx, 32'd256);
        chk("e_done_cnt", done_cnt, 32'd2);
        chk("e_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
